calc2_req_sched: RTL and testbench

Request scheduler in front of the calc2 single-issue engine. It takes operation requests from 4 requester ports and arbitrates them round-robin. It serialises each granted request onto the engine's two-cycle cmd/operand bus and routes each engine response back to the originating port by tag. It also tracks outstanding tags per port and rejects illegal commands locally, without consuming engine slots.

---
 rtl/calc2_req_sched_if.sv | 74 +++++++
 rtl/calc2_req_sched.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_calc2_req_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc2_req_sched_if.sv
// calc2_req_sched_if: bundles the four requester ports, the engine
// cmd/operand and response buses, and the per-port response outputs of the
// calc2 request scheduler.
//   master : requesters and engine side (drives requests and engine responses)
//   slave  : the scheduler itself
// Optional: CALC2_SCHED_STATS_EN adds grant_cnt (4x16, packed port4..port1).
interface calc2_req_sched_if #(
  parameter int unsigned DATA_W = 32
);
  // requester ports 1..4
  logic              req1_valid, req2_valid, req3_valid, req4_valid;
  logic              req1_ready, req2_ready, req3_ready, req4_ready;
  logic [3:0]        req1_cmd, req2_cmd, req3_cmd, req4_cmd;
  logic [DATA_W-1:0] req1_op1, req2_op1, req3_op1, req4_op1;
  logic [DATA_W-1:0] req1_op2, req2_op2, req3_op2, req4_op2;
  logic [1:0]        req1_tag, req2_tag, req3_tag, req4_tag;

  // engine issue bus
  logic [3:0]        eng_cmd_out;
  logic [DATA_W-1:0] eng_data_out;
  logic [3:0]        eng_tag_out;

  // engine response bus
  logic [1:0]        eng_resp_in;
  logic [DATA_W-1:0] eng_data_in;
  logic [3:0]        eng_tag_in;

  // per-port responses
  logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
  logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
  logic [1:0]        out_tag1, out_tag2, out_tag3, out_tag4;

  logic              spurious_err;

`ifdef CALC2_SCHED_STATS_EN
  logic [3:0][15:0]  grant_cnt;
`endif

  modport master (
`ifdef CALC2_SCHED_STATS_EN
    input  grant_cnt,
`endif
    output req1_valid, req2_valid, req3_valid, req4_valid,
    input  req1_ready, req2_ready, req3_ready, req4_ready,
    output req1_cmd, req2_cmd, req3_cmd, req4_cmd,
    output req1_op1, req2_op1, req3_op1, req4_op1,
    output req1_op2, req2_op2, req3_op2, req4_op2,
    output req1_tag, req2_tag, req3_tag, req4_tag,
    input  eng_cmd_out, eng_data_out, eng_tag_out,
    output eng_resp_in, eng_data_in, eng_tag_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_tag1, out_tag2, out_tag3, out_tag4,
    input  spurious_err
  );

  modport slave (
`ifdef CALC2_SCHED_STATS_EN
    output grant_cnt,
`endif
    input  req1_valid, req2_valid, req3_valid, req4_valid,
    output req1_ready, req2_ready, req3_ready, req4_ready,
    input  req1_cmd, req2_cmd, req3_cmd, req4_cmd,
    input  req1_op1, req2_op1, req3_op1, req4_op1,
    input  req1_op2, req2_op2, req3_op2, req4_op2,
    input  req1_tag, req2_tag, req3_tag, req4_tag,
    output eng_cmd_out, eng_data_out, eng_tag_out,
    input  eng_resp_in, eng_data_in, eng_tag_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4,
    output out_tag1, out_tag2, out_tag3, out_tag4,
    output spurious_err
  );
endinterface

// File: rtl/calc2_req_sched.sv
// calc2_req_sched: round-robin request scheduler in front of the calc2
// single-issue engine. It grants one of four requester ports per cycle,
// serialises legal commands onto the two-cycle cmd/operand engine bus, routes
// engine responses back by tag, tracks outstanding tags per port, and answers
// illegal commands locally with an error response.
// Ports:
//   c_clk  - clock
//   reset  - asynchronous active-low reset
//   bus    - calc2_req_sched_if.slave: reqN_* (N=1..4), eng_* issue and
//            response buses, out_respN/out_dataN/out_tagN, spurious_err
// Optional: CALC2_SCHED_STATS_EN adds bus.grant_cnt, per-port saturating
// 16-bit counters of legal grants.
module calc2_req_sched #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic             c_clk,
  input  logic             reset,
  calc2_req_sched_if.slave bus
);

  localparam int unsigned NPORT = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE1 = 2'd1,
    ISSUE2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  // request fields gathered into arrays indexed by port
  logic [NPORT-1:0]  req_valid;
  logic [3:0]        req_cmd [NPORT];
  logic [DATA_W-1:0] req_op1 [NPORT];
  logic [DATA_W-1:0] req_op2 [NPORT];
  logic [1:0]        req_tag [NPORT];

  assign req_valid  = {bus.req4_valid, bus.req3_valid, bus.req2_valid, bus.req1_valid};
  assign req_cmd[0] = bus.req1_cmd;
  assign req_cmd[1] = bus.req2_cmd;
  assign req_cmd[2] = bus.req3_cmd;
  assign req_cmd[3] = bus.req4_cmd;
  assign req_op1[0] = bus.req1_op1;
  assign req_op1[1] = bus.req2_op1;
  assign req_op1[2] = bus.req3_op1;
  assign req_op1[3] = bus.req4_op1;
  assign req_op2[0] = bus.req1_op2;
  assign req_op2[1] = bus.req2_op2;
  assign req_op2[2] = bus.req3_op2;
  assign req_op2[3] = bus.req4_op2;
  assign req_tag[0] = bus.req1_tag;
  assign req_tag[1] = bus.req2_tag;
  assign req_tag[2] = bus.req3_tag;
  assign req_tag[3] = bus.req4_tag;

  // tracking state
  logic [NPORT-1:0][3:0] busy_q;
  logic [CNT_W-1:0]      cnt_q [NPORT];
  logic [NPORT-1:0]      rej_pend_q;
  logic [1:0]            rej_tag_q [NPORT];
  logic [1:0]            rr_q;          // first port to consider next
  logic                  spur_q;

  // registered outputs
  logic [3:0]        eng_cmd_q;
  logic [DATA_W-1:0] eng_data_q;
  logic [3:0]        eng_tag_q;
  logic [DATA_W-1:0] op2_q;
  logic [1:0]        out_resp_q [NPORT];
  logic [DATA_W-1:0] out_data_q [NPORT];
  logic [1:0]        out_tag_q  [NPORT];

  function automatic logic cmd_legal(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // Per-port eligibility from current tracking state
  logic [NPORT-1:0] elig;
  always_comb begin
    elig = '0;
    for (int n = 0; n < NPORT; n++) begin
      elig[n] = req_valid[n] && !busy_q[n][req_tag[n]] &&
                (cnt_q[n] < CNT_W'(MAX_OUTSTANDING)) && !rej_pend_q[n];
    end
  end

  // Round-robin arbiter; ready must stay low while reset is held
  logic       arb_en;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  assign arb_en = reset && ((state_q == IDLE) || (state_q == ISSUE2));

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (arb_en) begin
      for (int i = 0; i < NPORT; i++) begin
        cand = rr_q + 2'(i);
        if (!grant_vld && elig[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  logic [3:0] grant_cmd;
  logic       grant_legal;
  assign grant_cmd   = req_cmd[grant_idx];
  assign grant_legal = grant_vld && cmd_legal(grant_cmd);

  logic [NPORT-1:0] ready;
  always_comb begin
    ready = '0;
    if (grant_vld) ready[grant_idx] = 1'b1;
  end

  assign bus.req1_ready = ready[0];
  assign bus.req2_ready = ready[1];
  assign bus.req3_ready = ready[2];
  assign bus.req4_ready = ready[3];

  // Engine response decode; only an outstanding tag is a real retirement
  logic [1:0] rsp_port;
  logic [1:0] rsp_tag;
  logic       rsp_vld;
  logic       rsp_hit;
  assign rsp_port = bus.eng_tag_in[3:2];
  assign rsp_tag  = bus.eng_tag_in[1:0];
  assign rsp_vld  = (bus.eng_resp_in != 2'd0);
  assign rsp_hit  = rsp_vld && busy_q[rsp_port][rsp_tag];

  // Per-port set/clear/reject strobes
  logic [NPORT-1:0] set_v;
  logic [NPORT-1:0] clr_v;
  logic [NPORT-1:0] rej_new;
  always_comb begin
    set_v   = '0;
    clr_v   = '0;
    rej_new = '0;
    for (int n = 0; n < NPORT; n++) begin
      set_v[n]   = grant_legal && (grant_idx == 2'(n));
      clr_v[n]   = rsp_hit && (rsp_port == 2'(n));
      rej_new[n] = grant_vld && !grant_legal && (grant_idx == 2'(n));
    end
  end

  // FSM state register
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_legal) state_d = ISSUE1;
      ISSUE1:  state_d = ISSUE2;
      ISSUE2:  state_d = grant_legal ? ISSUE1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine issue bus, loaded for the state being entered
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      eng_cmd_q  <= '0;
      eng_data_q <= '0;
      eng_tag_q  <= '0;
      op2_q      <= '0;
    end else begin
      case (state_d)
        ISSUE1: begin
          eng_cmd_q  <= grant_cmd;
          eng_data_q <= req_op1[grant_idx];
          eng_tag_q  <= {grant_idx, req_tag[grant_idx]};
          op2_q      <= req_op2[grant_idx];
        end
        ISSUE2: begin
          eng_cmd_q  <= '0;
          eng_data_q <= op2_q;
        end
        default: begin
          eng_cmd_q  <= '0;
          eng_data_q <= '0;
          eng_tag_q  <= '0;
        end
      endcase
    end
  end

  // Outstanding-tag tracking and round-robin pointer
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      rr_q   <= '0;
      spur_q <= 1'b0;
      for (int n = 0; n < NPORT; n++) cnt_q[n] <= '0;
    end else begin
      if (grant_vld) rr_q <= grant_idx + 2'd1;
      if (rsp_vld && !rsp_hit) spur_q <= 1'b1;
      for (int n = 0; n < NPORT; n++) begin
        // set and clear never hit the same tag: a busy tag blocks its grant
        if (set_v[n]) busy_q[n][req_tag[n]] <= 1'b1;
        if (clr_v[n]) busy_q[n][rsp_tag]    <= 1'b0;
        case ({set_v[n], clr_v[n]})
          2'b10:   cnt_q[n] <= cnt_q[n] + CNT_W'(1);
          2'b01:   cnt_q[n] <= cnt_q[n] - CNT_W'(1);
          default: cnt_q[n] <= cnt_q[n];
        endcase
      end
    end
  end

  // Per-port response outputs; engine responses take priority over rejects
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rej_pend_q <= '0;
      for (int n = 0; n < NPORT; n++) begin
        rej_tag_q[n]  <= '0;
        out_resp_q[n] <= '0;
        out_data_q[n] <= '0;
        out_tag_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NPORT; n++) begin
        if (clr_v[n]) begin
          out_resp_q[n] <= bus.eng_resp_in;
          out_data_q[n] <= bus.eng_data_in;
          out_tag_q[n]  <= rsp_tag;
          if (rej_new[n]) begin
            rej_pend_q[n] <= 1'b1;
            rej_tag_q[n]  <= req_tag[n];
          end
        end else if (rej_pend_q[n]) begin
          out_resp_q[n] <= 2'd2;
          out_data_q[n] <= '0;
          out_tag_q[n]  <= rej_tag_q[n];
          rej_pend_q[n] <= 1'b0;
        end else if (rej_new[n]) begin
          out_resp_q[n] <= 2'd2;
          out_data_q[n] <= '0;
          out_tag_q[n]  <= req_tag[n];
        end else begin
          out_resp_q[n] <= '0;
          out_data_q[n] <= '0;
          out_tag_q[n]  <= '0;
        end
      end
    end
  end

`ifdef CALC2_SCHED_STATS_EN
  localparam int unsigned GCNT_W = 16;
  logic [NPORT-1:0][GCNT_W-1:0] gcnt_q;

  // Saturating legal-grant counters
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      gcnt_q <= '0;
    end else begin
      for (int n = 0; n < NPORT; n++) begin
        if (set_v[n] && (gcnt_q[n] != {GCNT_W{1'b1}})) gcnt_q[n] <= gcnt_q[n] + GCNT_W'(1);
      end
    end
  end

  assign bus.grant_cnt = gcnt_q;
`endif

  assign bus.eng_cmd_out  = eng_cmd_q;
  assign bus.eng_data_out = eng_data_q;
  assign bus.eng_tag_out  = eng_tag_q;
  assign bus.spurious_err = spur_q;

  assign bus.out_resp1 = out_resp_q[0];
  assign bus.out_resp2 = out_resp_q[1];
  assign bus.out_resp3 = out_resp_q[2];
  assign bus.out_resp4 = out_resp_q[3];
  assign bus.out_data1 = out_data_q[0];
  assign bus.out_data2 = out_data_q[1];
  assign bus.out_data3 = out_data_q[2];
  assign bus.out_data4 = out_data_q[3];
  assign bus.out_tag1  = out_tag_q[0];
  assign bus.out_tag2  = out_tag_q[1];
  assign bus.out_tag3  = out_tag_q[2];
  assign bus.out_tag4  = out_tag_q[3];

endmodule

// File: tb/tb_calc2_req_sched.sv
// tb_calc2_req_sched: directed bench for calc2_req_sched with a behavioural
// scoreboard model compared every cycle, plus literal expectations.
module tb_calc2_req_sched;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_OUT = 4;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  calc2_req_sched_if #(.DATA_W(DATA_W)) bus ();

  calc2_req_sched #(.DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus
  logic [3:0]  s_valid;
  logic [3:0]  s_cmd [4];
  logic [31:0] s_op1 [4];
  logic [31:0] s_op2 [4];
  logic [1:0]  s_tag [4];
  logic [1:0]  s_eresp;
  logic [31:0] s_edata;
  logic [3:0]  s_etag;

  assign bus.req1_valid = s_valid[0];
  assign bus.req2_valid = s_valid[1];
  assign bus.req3_valid = s_valid[2];
  assign bus.req4_valid = s_valid[3];
  assign bus.req1_cmd = s_cmd[0];
  assign bus.req2_cmd = s_cmd[1];
  assign bus.req3_cmd = s_cmd[2];
  assign bus.req4_cmd = s_cmd[3];
  assign bus.req1_op1 = s_op1[0];
  assign bus.req2_op1 = s_op1[1];
  assign bus.req3_op1 = s_op1[2];
  assign bus.req4_op1 = s_op1[3];
  assign bus.req1_op2 = s_op2[0];
  assign bus.req2_op2 = s_op2[1];
  assign bus.req3_op2 = s_op2[2];
  assign bus.req4_op2 = s_op2[3];
  assign bus.req1_tag = s_tag[0];
  assign bus.req2_tag = s_tag[1];
  assign bus.req3_tag = s_tag[2];
  assign bus.req4_tag = s_tag[3];
  assign bus.eng_resp_in = s_eresp;
  assign bus.eng_data_in = s_edata;
  assign bus.eng_tag_in  = s_etag;

  // DUT outputs as arrays
  logic [3:0]  d_ready;
  logic [1:0]  d_resp [4];
  logic [31:0] d_data [4];
  logic [1:0]  d_tag  [4];
  assign d_ready = {bus.req4_ready, bus.req3_ready, bus.req2_ready, bus.req1_ready};
  assign d_resp[0] = bus.out_resp1;
  assign d_resp[1] = bus.out_resp2;
  assign d_resp[2] = bus.out_resp3;
  assign d_resp[3] = bus.out_resp4;
  assign d_data[0] = bus.out_data1;
  assign d_data[1] = bus.out_data2;
  assign d_data[2] = bus.out_data3;
  assign d_data[3] = bus.out_data4;
  assign d_tag[0]  = bus.out_tag1;
  assign d_tag[1]  = bus.out_tag2;
  assign d_tag[2]  = bus.out_tag3;
  assign d_tag[3]  = bus.out_tag4;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding tags are a set per port; the outstanding count is its size.
  // The engine bus is modelled as reserved through the op2 cycle of the last
  // issue; a new grant is only possible once that cycle is not in the future.
  bit          m_busy [4][4];
  bit          m_rej_pend [4];
  logic [1:0]  m_rej_tag [4];
  int          m_last;
  int          m_cyc;
  int          m_op2_cyc;
  bit          m_op2_due;
  logic [31:0] m_op2;
  logic [3:0]  m_op2_tag;
  logic [3:0]  e_cmd, e_tag;
  logic [31:0] e_data;
  logic [1:0]  e_resp [4];
  logic [31:0] e_odata [4];
  logic [1:0]  e_otag [4];
  bit          e_spur;
  int          e_gcnt [4];

  function automatic bit legal_cmd(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  function automatic int n_busy(input int p);
    int k = 0;
    for (int t = 0; t < 4; t++) if (m_busy[p][t]) k++;
    return k;
  endfunction

  function automatic int model_grant();
    if (!reset) return -1;
    if (m_op2_cyc > m_cyc) return -1;
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (m_last + k) % 4;
      if (s_valid[p] && !m_rej_pend[p] && !m_busy[p][s_tag[p]] && n_busy(p) < MAX_OUT)
        return p;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < 4; p++) begin
      for (int t = 0; t < 4; t++) m_busy[p][t] = 1'b0;
      m_rej_pend[p] = 1'b0; m_rej_tag[p] = '0;
      e_resp[p] = '0; e_odata[p] = '0; e_otag[p] = '0; e_gcnt[p] = 0;
    end
    m_last = 3; m_cyc = 0; m_op2_cyc = 0; m_op2_due = 1'b0;
    m_op2 = '0; m_op2_tag = '0;
    e_cmd = '0; e_tag = '0; e_data = '0; e_spur = 1'b0;
  endtask

  task automatic m_step();
    int g, hp;
    bit legal;
    g  = model_grant();
    hp = -1;
    legal = (g >= 0) && legal_cmd(s_cmd[g]);
    if (s_eresp != 2'd0) begin
      if (m_busy[s_etag[3:2]][s_etag[1:0]]) hp = int'(s_etag[3:2]);
      else e_spur = 1'b1;
    end
    // engine bus for the next cycle
    if (m_op2_due) begin
      e_cmd = '0; e_data = m_op2; e_tag = m_op2_tag; m_op2_due = 1'b0;
    end else if (legal) begin
      e_cmd = s_cmd[g]; e_data = s_op1[g]; e_tag = {2'(g), s_tag[g]};
      m_op2 = s_op2[g]; m_op2_tag = e_tag; m_op2_due = 1'b1;
      m_op2_cyc = m_cyc + 2;
    end else begin
      e_cmd = '0; e_data = '0; e_tag = '0;
    end
    if (g >= 0) begin
      m_last = g;
      if (legal) begin
        m_busy[g][s_tag[g]] = 1'b1;
        if (e_gcnt[g] < 65535) e_gcnt[g]++;
      end else begin
        m_rej_pend[g] = 1'b1;
        m_rej_tag[g]  = s_tag[g];
      end
    end
    if (hp >= 0) m_busy[hp][s_etag[1:0]] = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (hp == p) begin
        e_resp[p] = s_eresp; e_odata[p] = s_edata; e_otag[p] = s_etag[1:0];
      end else if (m_rej_pend[p]) begin
        e_resp[p] = 2'd2; e_odata[p] = '0; e_otag[p] = m_rej_tag[p];
        m_rej_pend[p] = 1'b0;
      end else begin
        e_resp[p] = '0; e_odata[p] = '0; e_otag[p] = '0;
      end
    end
    m_cyc++;
  endtask

  always @(posedge c_clk or negedge reset) begin
    if (!reset) m_reset();
    else        m_step();
  end

  // per-cycle comparison against the model
  always @(negedge c_clk) begin
    if (chk_en) begin
      int g;
      g = model_grant();
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("ready%0d", p + 1), d_ready[p], (g == p));
        chk($sformatf("out_resp%0d", p + 1), d_resp[p], e_resp[p]);
        chk($sformatf("out_data%0d", p + 1), d_data[p], e_odata[p]);
        chk($sformatf("out_tag%0d", p + 1), d_tag[p], e_otag[p]);
`ifdef CALC2_SCHED_STATS_EN
        chk($sformatf("grant_cnt%0d", p + 1), bus.grant_cnt[p], e_gcnt[p]);
`endif
      end
      chk("eng_cmd_out", bus.eng_cmd_out, e_cmd);
      chk("eng_data_out", bus.eng_data_out, e_data);
      chk("eng_tag_out", bus.eng_tag_out, e_tag);
      chk("spurious_err", bus.spurious_err, e_spur);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Hold a request until granted (bounded); returns with valid cleared
  task automatic send(input int p, input logic [3:0] cmd, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] tag, output bit ok);
    s_valid[p] = 1'b1; s_cmd[p] = cmd; s_op1[p] = a; s_op2[p] = b; s_tag[p] = tag;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge c_clk);
      if (d_ready[p]) ok = 1'b1;
      step();
    end
    s_valid[p] = 1'b0;
  endtask

  task automatic eng_respond(input logic [1:0] r, input logic [31:0] d, input logic [3:0] t);
    s_eresp = r; s_edata = d; s_etag = t;
    step();
    s_eresp = '0; s_edata = '0; s_etag = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int seq [16];
    int gi;
    s_valid = '0; s_eresp = '0; s_edata = '0; s_etag = '0;
    for (int p = 0; p < 4; p++) begin
      s_cmd[p] = '0; s_op1[p] = '0; s_op2[p] = '0; s_tag[p] = '0;
    end
    step();
    step();
    chk_en = 1'b1;
    @(negedge c_clk);
    chk("rst_eng_cmd", bus.eng_cmd_out, 4'd0);
    chk("rst_spur", bus.spurious_err, 1'b0);
    step();
    reset = 1'b1;

    // single add on port 1
    send(0, 4'd1, 32'd5, 32'd7, 2'd2, ok);
    chk("add_grant", ok, 1'b1);
    @(negedge c_clk);
    chk("add_c1_cmd", bus.eng_cmd_out, 4'd1);
    chk("add_c1_data", bus.eng_data_out, 32'd5);
    chk("add_c1_tag", bus.eng_tag_out, 4'h2);
    @(negedge c_clk);
    chk("add_c2_cmd", bus.eng_cmd_out, 4'd0);
    chk("add_c2_data", bus.eng_data_out, 32'd7);
    step();
    eng_respond(2'd1, 32'd12, 4'h2);
    @(negedge c_clk);
    chk("add_resp", bus.out_resp1, 2'd1);
    chk("add_rdata", bus.out_data1, 32'd12);
    chk("add_rtag", bus.out_tag1, 2'd2);
    step();

    // round robin with all ports requesting continuously
    do_reset();
    for (int p = 0; p < 4; p++) begin
      s_valid[p] = 1'b1; s_cmd[p] = (p % 2 == 1) ? 4'd2 : 4'd1;
      s_op1[p] = 32'(p * 16 + 3); s_op2[p] = 32'(p * 16 + 9); s_tag[p] = '0;
    end
    gi = 0;
    for (int c = 0; c < 16; c++) begin
      int gp;
      gp = -1;
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) if (d_ready[p]) gp = p;
      if (gp >= 0) begin seq[gi] = gp; gi++; end
      step();
      if (gp >= 0) s_tag[gp] = s_tag[gp] + 2'd1;
    end
    s_valid = '0;
    chk("rr_grants", gi, 8);
    for (int k = 0; k < 8; k++) if (k < gi) chk($sformatf("rr_seq%0d", k), seq[k], k % 4);

    // port 2 fills all four tags, then frees tag 0
    do_reset();
    for (int t = 0; t < 4; t++) begin
      send(1, 4'd5, 32'(t + 1), 32'd1, 2'(t), ok);
      chk("p2_fill", ok, 1'b1);
    end
    s_valid[1] = 1'b1; s_cmd[1] = 4'd6; s_op1[1] = 32'h80; s_op2[1] = 32'd2; s_tag[1] = 2'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge c_clk);
      chk("p2_blocked", d_ready[1], 1'b0);
      step();
    end
    eng_respond(2'd1, 32'hAB, 4'h4);
    @(negedge c_clk);
    chk("p2_ret_resp", bus.out_resp2, 2'd1);
    chk("p2_ret_data", bus.out_data2, 32'hAB);
    chk("p2_regrant", d_ready[1], 1'b1);
    step();
    s_valid = '0;
    repeat (3) step();

    // illegal command on port 3, then a reject colliding with a response
    do_reset();
    send(2, 4'd4, 32'd9, 32'd9, 2'd1, ok);
    chk("rej_grant", ok, 1'b1);
    @(negedge c_clk);
    chk("rej_resp", bus.out_resp3, 2'd2);
    chk("rej_tag", bus.out_tag3, 2'd1);
    chk("rej_no_eng", bus.eng_cmd_out, 4'd0);
    step();
    send(2, 4'd1, 32'd3, 32'd4, 2'd0, ok);
    repeat (3) step();
    s_valid[2] = 1'b1; s_cmd[2] = 4'd4; s_tag[2] = 2'd1;
    s_eresp = 2'd1; s_edata = 32'h77; s_etag = 4'h8;
    @(negedge c_clk);
    chk("col_grant", d_ready[2], 1'b1);
    step();
    s_valid = '0; s_eresp = '0; s_edata = '0; s_etag = '0;
    @(negedge c_clk);
    chk("col_eng_first", bus.out_resp3, 2'd1);
    chk("col_eng_data", bus.out_data3, 32'h77);
    step();
    @(negedge c_clk);
    chk("col_rej_next", bus.out_resp3, 2'd2);
    chk("col_rej_tag", bus.out_tag3, 2'd1);
    step();

    // spurious response
    do_reset();
    eng_respond(2'd1, 32'h55, 4'hF);
    @(negedge c_clk);
    chk("spur_set", bus.spurious_err, 1'b1);
    chk("spur_no_resp4", bus.out_resp4, 2'd0);
    step();

    // reset while in ISSUE1
    do_reset();
    send(1, 4'd1, 32'd1, 32'd2, 2'd3, ok);
    chk("mid_issue_cmd", bus.eng_cmd_out, 4'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd", bus.eng_cmd_out, 4'd0);
    chk("mid_rst_data", bus.eng_data_out, 32'd0);
    chk("mid_rst_tag", bus.eng_tag_out, 4'd0);
    step();
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin
      s_valid[p] = 1'b1; s_cmd[p] = 4'd2; s_op1[p] = 32'd10; s_op2[p] = 32'd4; s_tag[p] = 2'(p);
    end
    @(negedge c_clk);
    chk("post_rst_port1", d_ready, 4'b0001);
    step();
    s_valid = '0;
    repeat (3) step();
    eng_respond(2'd1, 32'd0, 4'h7);
    @(negedge c_clk);
    chk("post_rst_spur", bus.spurious_err, 1'b1);
    repeat (2) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
